// File: rtl/chan_mux_pkg.sv
// Shared definitions for the chan_mux_rr channel multiplexer.
//   mode_e : selects FIXED (sel-driven) or RR (round-robin) channel choice.
package chan_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Width of a channel index, never narrower than one bit.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/chan_mux_rr_if.sv
// Bus bundle for chan_mux_rr: control, per-channel valid/ready/data inputs,
// and the single registered output channel.
//   master : producer/consumer side (drives mode, sel, in_*, out_ready)
//   slave  : multiplexer side (drives in_ready and out_*)
interface chan_mux_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Scans req starting at ptr and wrapping
// modulo NUM_CH; the first requesting channel wins. The pointer register is
// owned by the instantiating module.
//   req     : per-channel request
//   ptr     : channel with highest priority this cycle
//   en      : when low, no grant is produced
//   gnt     : one-hot grant
//   gnt_idx : index of granted channel
//   gnt_vld : a grant was produced
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);
    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        if (en) begin
            // Walk offsets from farthest to nearest so the nearest requester
            // to ptr is the last one written and therefore wins.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % NUM_CH;
                if (req[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(idx);
                end
            end
            if (gnt_vld) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/chan_mux_rr.sv
// N-channel valid/ready multiplexer with a single registered output stage.
// FIXED mode forwards the channel named by sel; RR mode arbitrates
// round-robin among valid channels, advancing rr_ptr past each accepted grant.
//   clk, rst : clock and synchronous active-high reset
//   bus      : chan_mux_rr_if slave port (mode, sel, in_*, out_*)
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    chan_mux_rr_if.slave bus
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic [SEL_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [SEL_W-1:0]  out_ch_reg;

    logic              rr_en;
    logic [NUM_CH-1:0] rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_vld;

    logic [NUM_CH-1:0] fixed_onehot;
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic              load;
    logic              take;

    assign rr_en = (bus.mode == MODE_RR);

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_reg),
        .en      (rr_en),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // sel values >= NUM_CH match no bit here, so they simply yield no grant.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign fixed_onehot[gi] = (bus.sel == SEL_W'(gi));
        assign ch_data[gi]      = bus.in_data[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (rr_en) begin
            grant_valid = rr_vld;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = |(fixed_onehot & bus.in_valid);
            grant_idx   = bus.sel;
        end
    end

    // The register can take a word when empty or when its word leaves now.
    assign load = !out_valid_reg || bus.out_ready;
    assign take = !rst && load && grant_valid;

    assign bus.in_ready = take ? (rr_en ? rr_gnt : fixed_onehot) : '0;

    assign rr_ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            if (take) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ch_data[grant_idx];
                out_ch_reg    <= grant_idx;
                if (rr_en) begin
                    rr_ptr_reg <= rr_ptr_next;
                end
            end else if (load) begin
                // Drain with nothing to replace it; payload keeps its last value.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
endmodule

// File: tb/tb_chan_mux_rr.sv
module tb_chan_mux_rr;
    import chan_mux_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chan_mux_rr_if #(.NUM_CH(N), .DATA_W(W)) bus();

    chan_mux_rr #(.NUM_CH(N), .DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference state: what the output register should hold, and the
    // round-robin priority channel.
    bit           m_known = 0;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel that the rules pick this cycle, or -1.
    function automatic int ref_grant(input bit md, input int sl, input logic [N-1:0] v);
        if (md == MODE_RR) begin
            for (int k = 0; k < N; k++)
                if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
            return -1;
        end
        if (sl < N && v[sl]) return sl;
        return -1;
    endfunction

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // One clock of stimulus: drive on the falling edge, check the
    // combinational ready and current outputs, then advance the model.
    task automatic step(input bit md, input int sl, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input bit ordy, input bit r);
        bit load;
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst           = r;
        bus.mode      = md;
        bus.sel       = SW'(sl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        load    = !m_known || !m_valid || ordy;
        g       = (r || !load) ? -1 : ref_grant(md, sl, v);
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (m_known) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("out_data", 32'(bus.out_data), 32'(m_data));
            chk("out_ch", 32'(bus.out_ch), 32'(m_ch));
        end
        txn++;
        $display("txn %0d rst=%0b mode=%0b sel=%0d in_valid=%b out_ready=%0b in_ready=%b grant=%0d",
                 txn, r, md, sl, v, ordy, bus.in_ready, g);
        @(posedge clk);
        if (r) begin
            m_known = 1;
            m_valid = 0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = d[g*W +: W];
            m_ch    = g;
            if (md == MODE_RR) m_ptr = (g + 1) % N;
        end else if (load) begin
            m_valid = 0;
        end
        #1;
    endtask

    logic [N*W-1:0] inc_data;

    initial begin
        rst           = 1'b1;
        bus.mode      = MODE_RR;
        bus.sel       = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        inc_data      = pack(8'h10, 8'h11, 8'h12, 8'h13);

        // Reset held two cycles with every channel valid.
        step(MODE_RR, 0, 4'hF, inc_data, 1, 1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        step(MODE_RR, 0, 4'hF, inc_data, 1, 1);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        step(MODE_RR, 0, 4'hF, inc_data, 1, 0);
        chk("first_grant_ch", 32'(bus.out_ch), 32'd0);
        chk("first_grant_valid", 32'(bus.out_valid), 32'd1);

        // FIXED mode, valid and invalid selection.
        step(MODE_FIXED, 2, 4'b0100, pack(8'h00, 8'h00, 8'hA5, 8'h00), 1, 0);
        chk("fixed_data", 32'(bus.out_data), 32'hA5);
        chk("fixed_ch", 32'(bus.out_ch), 32'd2);
        step(MODE_FIXED, 1, 4'b0100, pack(8'h00, 8'h00, 8'hA5, 8'h00), 1, 0);
        chk("fixed_nogrant_valid", 32'(bus.out_valid), 32'd0);

        // Round robin over all channels from a fresh pointer.
        step(MODE_RR, 0, 4'h0, inc_data, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(MODE_RR, 0, 4'hF, inc_data, 1, 0);
            chk("rr_seq_ch", 32'(bus.out_ch), 32'(i % N));
            chk("rr_seq_data", 32'(bus.out_data), 32'(8'h10 + i % N));
        end

        // Pointer at 3 with only ch1 valid: scan wraps to ch1, pointer -> 2.
        step(MODE_RR, 0, 4'b0100, inc_data, 1, 0);
        step(MODE_RR, 0, 4'b0010, inc_data, 1, 0);
        chk("wrap_ch", 32'(bus.out_ch), 32'd1);
        step(MODE_RR, 0, 4'hF, inc_data, 1, 0);
        chk("ptr_after_wrap", 32'(bus.out_ch), 32'd2);

        // Backpressure hold then same-cycle reload.
        step(MODE_FIXED, 0, 4'b0001, pack(8'h33, 8'h00, 8'h00, 8'h00), 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(MODE_RR, 0, 4'hF, inc_data, 0, 0);
            chk("stall_data", 32'(bus.out_data), 32'h33);
        end
        step(MODE_RR, 0, 4'hF, inc_data, 1, 0);
        chk("reload_valid", 32'(bus.out_valid), 32'd1);
        chk("reload_data", 32'(bus.out_data), 32'h13);

        // Reset while holding a stalled word.
        step(MODE_FIXED, 3, 4'b1000, pack(8'h00, 8'h00, 8'h00, 8'h77), 1, 0);
        step(MODE_FIXED, 3, 4'b1000, pack(8'h00, 8'h00, 8'h00, 8'h77), 0, 1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        step(MODE_RR, 0, 4'hF, inc_data, 1, 0);
        chk("midrst_ptr_ch", 32'(bus.out_ch), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, N - 1), N'($urandom),
                 (N*W)'({$urandom, $urandom}), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
